// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring 32-bit divider for DIV/DIVU, one quotient bit per cycle.
// Returns {remainder, quotient}; a zero divisor yields an all-zero result.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);
  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;
  state_t      state;
  logic [5:0]  cnt;
  logic [63:0] w;
  logic [31:0] b_mag, a_mag_in, b_mag_in, rem_nx, q_nx, q_fin, r_fin;
  logic [32:0] diff;
  logic        a_neg, b_neg, sgn, go;
  // The 65-bit working value's top bit is only needed after a step, so it is
  // taken from rem_nx rather than stored.
  always_comb begin
    go       = start_i && !annul_i;
    a_mag_in = signed_div_i && opdata1_i[31] ? -opdata1_i : opdata1_i;
    b_mag_in = signed_div_i && opdata2_i[31] ? -opdata2_i : opdata2_i;
    diff     = {1'b0, w[63:32]} - {1'b0, b_mag};
    rem_nx   = diff[32] ? w[63:32] : diff[31:0];
    q_nx     = {w[30:0], ~diff[32]};
    q_fin    = sgn && (a_neg ^ b_neg) ? -q_nx : q_nx;
    r_fin    = sgn && a_neg ? -rem_nx : rem_nx;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FREE;
      ready_o  <= 1'b0;
      result_o <= '0;
      cnt      <= '0;
      w        <= '0;
      b_mag    <= '0;
      a_neg    <= 1'b0;
      b_neg    <= 1'b0;
      sgn      <= 1'b0;
    end else begin
      case (state)
        FREE: begin
          ready_o  <= 1'b0;
          result_o <= '0;
          if (go) begin
            state <= opdata2_i == 32'd0 ? BYZERO : ON;
            cnt   <= '0;
            b_mag <= b_mag_in;
            a_neg <= opdata1_i[31];
            b_neg <= opdata2_i[31];
            sgn   <= signed_div_i;
            w     <= {31'b0, a_mag_in, 1'b0};
          end
        end
        BYZERO: begin
          state    <= go ? END : FREE;
          ready_o  <= go;
          result_o <= '0;
          cnt      <= '0;
        end
        ON: begin
          if (!go) begin
            state    <= FREE;
            ready_o  <= 1'b0;
            result_o <= '0;
            cnt      <= '0;
          end else begin
            w   <= {rem_nx[30:0], w[31:0], ~diff[32]};
            cnt <= cnt + 6'd1;
            if (cnt == 6'd31) begin
              state    <= END;
              ready_o  <= 1'b1;
              result_o <= {r_fin, q_fin};
            end
          end
        end
        END: begin
          if (!start_i) begin
            state    <= FREE;
            ready_o  <= 1'b0;
            result_o <= '0;
          end
        end
        default: state <= FREE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: randomized scoreboard bench for div_unit against an arithmetic reference model.
module tb_div_unit;
  logic        clk = 1'b0, rst = 1'b1, signed_div_i = 1'b0, start_i = 1'b0, annul_i = 1'b0;
  logic [31:0] opdata1_i = '0, opdata2_i = '0;
  logic [63:0] result_o;
  logic        ready_o;
  int          cyc = 0, n_cmp = 0, n_err = 0;
  typedef struct {
    logic [63:0] res;
    int          due;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  logic prev = 1'b0;

  div_unit dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i), .opdata1_i(opdata1_i),
    .opdata2_i(opdata2_i), .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Division on magnitudes with sign fix-ups; zero divisor defined as 0.
  function automatic logic [63:0] model(bit s, logic [31:0] a, logic [31:0] b);
    logic [63:0] ma, mb, qq, rr;
    bit na, nb;
    if (b == 32'd0) return 64'd0;
    na = s && a[31];
    nb = s && b[31];
    ma = na ? 64'h1_0000_0000 - {32'd0, a} : {32'd0, a};
    mb = nb ? 64'h1_0000_0000 - {32'd0, b} : {32'd0, b};
    qq = ma / mb;
    rr = ma % mb;
    if (na ^ nb) qq = -qq;
    if (na) rr = -rr;
    return {rr[31:0], qq[31:0]};
  endfunction

  always @(negedge clk) begin
    if (ready_o && !prev) begin
      if (sb.size() == 0) chk("unexpected_ready", 64'(ready_o), 64'd0);
      else begin
        mon_e = sb.pop_front();
        chk("result", result_o, mon_e.res);
        chk("ready_cycle", 64'(cyc), 64'(mon_e.due));
      end
    end
    prev <= ready_o;
  end

  // Called at a negedge; that cycle is the start cycle N.
  task automatic run_op(bit s, logic [31:0] a, logic [31:0] b, int hold);
    logic [63:0] ex;
    exp_t e;
    bit got;
    ex = model(s, a, b);
    signed_div_i = s;
    opdata1_i = a;
    opdata2_i = b;
    start_i = 1'b1;
    e.res = ex;
    e.due = cyc + (b == 32'd0 ? 2 : 33);
    sb.push_back(e);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (i == 0) begin
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        signed_div_i = 1'($urandom);
      end
      got = ready_o;
    end
    if (!got) begin
      chk("ready_timeout", 64'(got), 64'd1);
      if (sb.size() > 0) void'(sb.pop_back());
    end
    repeat (hold) begin
      @(negedge clk);
      opdata1_i = $urandom;
      opdata2_i = $urandom;
      chk("hold_ready", 64'(ready_o), 64'd1);
      chk("hold_result", result_o, ex);
    end
    start_i = 1'b0;
    @(negedge clk);
    chk("drop_ready", 64'(ready_o), 64'd0);
    chk("drop_result", result_o, 64'd0);
  endtask

  initial begin
    bit s;
    logic [31:0] a, b;
    repeat (3) @(negedge clk);
    chk("reset_ready", 64'(ready_o), 64'd0);
    chk("reset_result", result_o, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    run_op(0, 32'd100, 32'd7, 0);
    run_op(1, 32'hFFFFFFF9, 32'd2, 0);
    run_op(1, 32'd7, 32'hFFFFFFFE, 0);
    run_op(0, 32'd1234, 32'd0, 0);
    run_op(1, 32'hFFFFFF00, 32'd0, 0);
    run_op(0, 32'hFFFFFFFF, 32'd1, 0);
    run_op(1, 32'h80000000, 32'hFFFFFFFF, 0);
    run_op(0, 32'h80000000, 32'hFFFFFFFF, 0);
    run_op(1, 32'hFFFFFF9C, 32'd7, 3);
    for (int k = 0; k < 30; k++) begin
      s = 1'($urandom);
      a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : 32'($urandom);
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'd0 - 32'($urandom_range(1, 15));
        default: b = 32'($urandom);
      endcase
      run_op(s, a, b, 0);
    end
    // Abort at N+10, then a fresh divide at N+12.
    signed_div_i = 1'b0;
    opdata1_i = 32'd1000;
    opdata2_i = 32'd3;
    start_i = 1'b1;
    repeat (10) @(negedge clk);
    annul_i = 1'b1;
    @(negedge clk);
    chk("annul_ready", 64'(ready_o), 64'd0);
    chk("annul_result", result_o, 64'd0);
    annul_i = 1'b0;
    start_i = 1'b0;
    @(negedge clk);
    run_op(0, 32'd9, 32'd3, 0);
    // Reset mid-operation at N+20, start held until N+25.
    signed_div_i = 1'b0;
    opdata1_i = 32'd12345;
    opdata2_i = 32'd7;
    start_i = 1'b1;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("rst_ready", 64'(ready_o), 64'd0);
      chk("rst_result", result_o, 64'd0);
    end
    rst = 1'b0;
    start_i = 1'b0;
    repeat (40) begin
      @(negedge clk);
      chk("idle_ready", 64'(ready_o), 64'd0);
    end
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider serving the EX stage for DIV/DIVU. It is the responder side of EX's multi-cycle request handshake: EX raises a start request and holds the pipeline stalled, and this block iterates one quotient bit per cycle. It returns a 64-bit {remainder, quotient} pair that EX forwards to the HI/LO write path through ex_mem. The block is self-contained sequential logic with a 4-state FSM and a 6-bit iteration counter.

## Interface
- No parameters; data width fixed at 32.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled at start.
- opdata1_i  in  32  dividend; sampled at start.
- opdata2_i  in  32  divisor; sampled at start.
- start_i  in  1  request from EX; held high until EX has consumed ready_o.
- annul_i  in  1  abort the current operation (flush or exception).
- result_o  out  64  [63:32] remainder (HI), [31:0] quotient (LO).
- ready_o  out  1  result_o valid.

## Operation
- States: FREE, BYZERO, ON, END. Reset: state FREE, ready_o=0, result_o=0, cnt=0, working register=0.
- FREE, start_i=1, annul_i=0:
  - If opdata2_i==0: go to BYZERO.
  - Otherwise: go to ON with cnt=0.
  - Latch the operand magnitudes. When signed_div_i=1 and the operand is negative, the magnitude is its two's complement; otherwise the raw value is used.
  - Latch the sign flags of dividend and divisor, and signed_div_i.
  - Working register w[64:0] = {32'b0, |dividend|, 1'b0}.
- FREE, any other input: stay in FREE with ready_o=0 and result_o=0.
- BYZERO: go to END with result_o=0 and ready_o=1. The MIPS result is undefined; this block defines it as 0.
- ON, start_i=1, annul_i=0: perform one restoring step per cycle.
  - Compute diff = {1'b0, w[63:32]} - {1'b0, |divisor|} as a 33-bit value.
  - diff[32]=1 (borrow): w <= {w[63:0], 1'b0}.
  - diff[32]=0: w <= {diff[31:0], w[31:0], 1'b1}.
  - cnt <= cnt+1.
- ON, after the step with cnt==31: go to END, set ready_o=1, and load result_o from the post-step value:
  - q = w[31:0].
  - r = w[64:33].
  - If signed and the operand signs differ, q is negated (two's complement).
  - If signed and the dividend is negative, r is negated.
  - Arithmetic wraps mod 2^32: 0x80000000 / 0xFFFFFFFF signed gives q=0x80000000, r=0.
- ON or BYZERO with annul_i=1 or start_i=0: go to FREE, ready_o=0, result_o=0, cnt=0. The partial result is discarded.
- END, start_i=1: hold. ready_o stays 1 and result_o is stable, even if operands change. annul_i is ignored in END because EX drops start_i on flush.
- END, start_i=0: go to FREE, ready_o=0, result_o=0.
- annul_i has priority over start_i in FREE: no operation begins.
- rst at any state, mid-operation included, forces the reset values on the next edge.

## Timing
- Cycle N = first cycle in FREE with start_i=1.
- Nonzero divisor:
  - ON during N+1 .. N+32, with cnt 0..31.
  - ready_o=1 first seen in cycle N+33.
  - Latency 33 cycles.
- Zero divisor: BYZERO in N+1; ready_o=1 in N+2.
- ready_o and result_o are registered outputs, with no combinational path from inputs.
- EX deasserts start_i in the cycle it observes ready_o=1. The block returns to FREE one edge later, so ready_o is high for exactly 1 cycle under nominal use.
- Back-to-back divides: a new start_i=1 seen in FREE is accepted in that cycle. This allows at minimum 1 idle FREE cycle between operations.
- Operands need only be valid in cycle N. The divisor magnitude and sign flags are held internally.

## Test plan
- Unsigned 100 / 7, start at N: ready_o=0 through N+32; result_o=0x00000002_0000000E in N+33; ready_o drops the cycle after start_i falls.
- Signed -7 / 2 (0xFFFFFFF9, 0x2) -> q=0xFFFFFFFD, r=0xFFFFFFFF. Signed 7 / -2 -> q=0xFFFFFFFD, r=0x00000001.
- Divisor 0 (either sign mode) -> ready_o=1 in N+2, result_o=0. Unsigned 0xFFFFFFFF / 1 -> q=0xFFFFFFFF, r=0 in N+33.
- Signed 0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0. Unsigned 0x80000000 / 0xFFFFFFFF -> q=0, r=0x80000000.
- annul_i=1 in N+10 -> FREE at N+11 with ready_o=0 and result_o=0. A fresh start of 9/3 at N+12 gives q=3, r=0 in N+45.
- rst=1 in N+20 -> all outputs 0 from N+21. start_i held high then drops in N+25 -> stays in FREE, and no ready_o ever asserts.
